// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART THR write port, grants held per message with burst cap.
module uart_tx_arbiter #(
  parameter int NumReq   = 4,
  parameter int MaxBurst = 16,
  parameter int IdxWidth = $clog2(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [NumReq*8-1:0]   req_data_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  logic                  tx_thr_empty_i,
  output logic                  tx_write_o,
  output logic [7:0]            tx_data_o,
  output logic [NumReq-1:0]     grant_o,
  output logic [IdxWidth-1:0]   grant_idx_o,
  output logic                  busy_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  logic [1:0]          r_state;
  logic [IdxWidth-1:0] r_owner;
  logic [IdxWidth-1:0] r_rr_ptr;
  logic [7:0]          r_cnt;
  logic                r_last;
  logic [IdxWidth-1:0] w_hi;
  logic [IdxWidth-1:0] w_lo;
  logic                w_hi_ok;
  logic [IdxWidth-1:0] w_pick;
  logic [IdxWidth-1:0] w_next_ptr;
  logic [NumReq-1:0]   w_onehot;
  logic                w_fire;
  logic                w_release;
  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    w_hi    = '0;
    w_lo    = '0;
    w_hi_ok = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req_valid_i[k]) w_lo = IdxWidth'(k);
      if (req_valid_i[k] && IdxWidth'(k) >= r_rr_ptr) begin
        w_hi    = IdxWidth'(k);
        w_hi_ok = 1'b1;
      end
    end
  end
  assign w_pick      = w_hi_ok ? w_hi : w_lo;
  assign w_next_ptr  = (r_owner == IdxWidth'(NumReq - 1)) ? '0 : r_owner + 1'b1;
  assign w_onehot    = NumReq'(1) << r_owner;
  assign w_fire      = (r_state == GRANT) && req_valid_i[r_owner] && tx_thr_empty_i;
  assign w_release   = r_last || (r_cnt == 8'(MaxBurst));
  assign busy_o      = r_state != IDLE;
  assign grant_o     = busy_o ? w_onehot : '0;
  assign req_ready_o = w_fire ? w_onehot : '0;
  assign tx_write_o  = w_fire;
  assign tx_data_o   = w_fire ? req_data_i[{r_owner, 3'b000} +: 8] : 8'h00;
  assign grant_idx_o = r_owner;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (|req_valid_i) begin
        r_state <= GRANT;
        r_owner <= w_pick;
        r_cnt   <= '0;
        r_last  <= 1'b0;
      end
    end else if (r_state == GRANT) begin
      if (w_fire) begin
        r_state <= HOLD;
        r_cnt   <= r_cnt + 8'(r_cnt != 8'(MaxBurst));
        r_last  <= req_last_i[r_owner];
      end
    end else begin
      // HOLD gives thr_empty a cycle to fall after the write before the next one.
      r_state <= w_release ? IDLE : GRANT;
      if (w_release) r_rr_ptr <= w_next_ptr;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, message hold, burst cap, pacing and async reset.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NR-1:0]   req_valid_i = '0;
  logic [NR*8-1:0] req_data_i = '0;
  logic [NR-1:0]   req_last_i = '0;
  logic [NR-1:0]   req_ready_o;
  logic            tx_thr_empty_i = 1'b1;
  logic            tx_write_o;
  logic [7:0]      tx_data_o;
  logic [NR-1:0]   grant_o;
  logic [1:0]      grant_idx_o;
  logic            busy_o;

  uart_tx_arbiter #(.NumReq(NR), .MaxBurst(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_thr_empty_i(tx_thr_empty_i),
    .tx_write_o(tx_write_o), .tx_data_o(tx_data_o), .grant_o(grant_o),
    .grant_idx_o(grant_idx_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_d [NR][32];
  logic       m_l [NR][32];
  int hd [NR];
  int tl [NR];
  logic [NR-1:0] mute = '0;
  logic thr = 1'b1;
  logic [7:0] wr_d [64];
  logic [1:0] wr_i [64];
  int n_wr = 0;
  logic          s_write;
  logic [7:0]    s_data;
  logic [NR-1:0] s_grant;
  logic [NR-1:0] s_ready;
  logic          s_busy;

  task check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task push(input int k, input logic [7:0] d, input logic l);
    m_d[k][tl[k]] = d;
    m_l[k][tl[k]] = l;
    tl[k]++;
  endtask

  task clear_q();
    for (int k = 0; k < NR; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end
    n_wr = 0;
    mute = '0;
    thr = 1'b1;
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
  endtask

  // One clock: requesters drive from their queues at negedge, outputs sampled 1ns later.
  task cyc();
    @(negedge clk_i);
    for (int k = 0; k < NR; k++) begin
      req_valid_i[k] = !mute[k] && (hd[k] < tl[k]);
      req_data_i[8*k +: 8] = (hd[k] < tl[k]) ? m_d[k][hd[k]] : 8'h00;
      req_last_i[k] = (hd[k] < tl[k]) ? m_l[k][hd[k]] : 1'b0;
    end
    tx_thr_empty_i = thr;
    #1;
    s_write = tx_write_o;
    s_data = tx_data_o;
    s_grant = grant_o;
    s_ready = req_ready_o;
    s_busy = busy_o;
    if (tx_write_o) begin
      wr_d[n_wr] = tx_data_o;
      wr_i[n_wr] = grant_idx_o;
      n_wr++;
    end
    for (int k = 0; k < NR; k++) if (req_ready_o[k]) hd[k]++;
    @(posedge clk_i);
  endtask

  task do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    clear_q();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    clear_q();
    #3;
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_write", tx_write_o, 0);
    check("rst_idx", grant_idx_o, 0);
    do_reset();

    // Single requester, three-byte message.
    push(2, 8'h41, 0); push(2, 8'h42, 0); push(2, 8'h43, 1);
    cyc(); check("t1_idle_nowr", s_write, 0); check("t1_idle_grant", s_grant, 0);
    cyc(); check("t1_w0", {s_write, s_data}, {1'b1, 8'h41}); check("t1_grant", s_grant, 4'b0100);
    cyc(); check("t1_hold0", s_write, 0); check("t1_hold_busy", s_busy, 1); check("t1_hold_grant", s_grant, 4'b0100);
    cyc(); check("t1_w1", {s_write, s_data}, {1'b1, 8'h42});
    cyc(); check("t1_hold1", s_write, 0);
    cyc(); check("t1_w2", {s_write, s_data}, {1'b1, 8'h43}); check("t1_ready", s_ready, 4'b0100);
    cyc(); check("t1_hold2_busy", s_busy, 1);
    cyc(); check("t1_done_busy", s_busy, 0); check("t1_done_grant", s_grant, 0);
    check("t1_idx_kept", grant_idx_o, 2);

    // Two requesters with back-to-back one-byte messages alternate.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, 8'hA0 + 8'(i), 1);
      push(1, 8'hB0 + 8'(i), 1);
    end
    repeat (18) cyc();
    check("t2_nwr", n_wr, 6);
    for (int i = 0; i < 6; i++) begin
      check("t2_idx", wr_i[i], 32'(i % 2));
      check("t2_data", wr_d[i], (i % 2 == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2));
    end

    // Burst cap releases a 20-byte message after 16 bytes.
    do_reset();
    for (int i = 0; i < 20; i++) push(3, 8'h30 + 8'(i), i == 19);
    cyc();
    push(0, 8'hA0, 1);
    repeat (50) cyc();
    check("t3_nwr", n_wr, 21);
    for (int i = 0; i < 21; i++) begin
      check("t3_idx", wr_i[i], (i == 16) ? 32'd0 : 32'd3);
      check("t3_data", wr_d[i], (i < 16) ? 32'h30 + 32'(i) : (i == 16) ? 32'hA0 : 32'h30 + 32'(i - 1));
    end

    // Transmitter not ready stalls the grant.
    do_reset();
    thr = 1'b0;
    push(1, 8'h55, 1);
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("t4_stall_wr", s_write, 0);
      check("t4_stall_rdy", s_ready, 0);
    end
    thr = 1'b1;
    cyc(); check("t4_resume", {s_write, s_data}, {1'b1, 8'h55}); check("t4_ready", s_ready, 4'b0010);

    // Asynchronous reset mid-burst, with rr_ptr moved off zero beforehand.
    do_reset();
    push(1, 8'h11, 1);
    repeat (3) cyc();
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
    cyc();
    cyc(); check("t5_pre_wr", {s_write, s_data}, {1'b1, 8'h21});
    @(negedge clk_i);
    #1;
    check("t5_pre_grant", grant_o, 4'b0100);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t5_async_grant", grant_o, 0);
    check("t5_async_busy", busy_o, 0);
    check("t5_async_idx", grant_idx_o, 0);
    check("t5_async_wr", {tx_write_o, tx_data_o, req_ready_o}, 0);
    clear_q();
    @(negedge clk_i);
    rst_ni = 1'b1;
    push(3, 8'h33, 1); push(0, 8'h0A, 1);
    cyc(); check("t5_idle", s_busy, 0);
    cyc(); check("t5_scan0_grant", s_grant, 4'b0001); check("t5_scan0_data", s_data, 8'h0A);

    // Owner pauses mid-message; the grant is held and others wait.
    do_reset();
    push(1, 8'h61, 0); push(1, 8'h62, 0); push(1, 8'h63, 1);
    push(2, 8'h71, 1);
    repeat (5) cyc();
    mute[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("t6_hold_grant", s_grant, 4'b0010);
      check("t6_hold_rdy", {s_write, s_ready}, 0);
    end
    mute[1] = 1'b0;
    repeat (5) cyc();
    check("t6_nwr", n_wr, 4);
    check("t6_seq", {wr_d[0], wr_d[1], wr_d[2], wr_d[3]}, 32'h61626371);
    check("t6_idx", {wr_i[0], wr_i[1], wr_i[2], wr_i[3]}, 8'b01010110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (THR write port) between NumReq on-chip requesters, e.g. debug console, bootloader, and a DMA-style stream.
- Round-robin arbitration. A grant is held for a whole message, ended by a last byte or by the MaxBurst cap, so bytes from different requesters never interleave mid-message.
- Paces THR writes from the transmitter's thr_empty status so no byte is ever overwritten.
- Sits between the requester fabric and the UART register/transmit path.

Parameters:
- NumReq, 4, number of requesters (2..8)
- MaxBurst, 16, maximum bytes per grant before forced release (1..255)
- IdxWidth, $clog2(NumReq), width of the grant index (derived; do not override)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  NumReq  per-requester byte valid
- req_data_i  input  NumReq*8  per-requester byte; requester k uses bits [8k+7:8k]
- req_last_i  input  NumReq  marks final byte of a message
- req_ready_o  output  NumReq  per-requester byte accepted (one-hot or zero)
- tx_thr_empty_i  input  1  transmitter can accept a byte (LSR thr_empty)
- tx_write_o  output  1  one-cycle THR write strobe
- tx_data_o  output  8  byte to THR, valid while tx_write_o=1
- grant_o  output  NumReq  one-hot current owner, zero when idle
- grant_idx_o  output  IdxWidth  index of current/last owner
- busy_o  output  1  high while a grant is held

Behaviour:
Reset values:
- One clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- During reset: all outputs 0, state IDLE, round-robin pointer 0, burst count 0.

States:
- IDLE
  - Select the first k with req_valid_i[k]=1, scanning from rr_ptr upward with wrap-around.
  - Next cycle: GRANT, owner=k, burst count=0.
  - No valid request: stay in IDLE.
  - Arbitration costs 1 cycle. No byte is accepted in the IDLE cycle.
- GRANT
  - grant_o=onehot(owner), busy_o=1.
  - When req_valid_i[owner]=1 and tx_thr_empty_i=1, in the same cycle:
    - req_ready_o[owner]=1, tx_write_o=1, tx_data_o=req_data_i[owner].
    - Burst count increments.
    - Next state is HOLD.
  - Other requesters' valid is ignored. Their ready stays 0.
- HOLD
  - One-cycle dead time so thr_empty can update after the write. No write in this cycle.
  - If the accepted byte had last=1, or burst count reached MaxBurst:
    - Release: rr_ptr=(owner+1) mod NumReq, then IDLE.
  - Otherwise: return to GRANT.

Handshake rules:
- req_ready_o is combinational from state, owner, req_valid_i and tx_thr_empty_i.
- At most one ready bit is high per cycle.
- tx_write_o equals OR of req_ready_o.
- A requester must hold data, last and valid stable until ready.
- Minimum spacing between tx_write_o pulses is 2 cycles.

Boundary conditions:
- Owner drops valid mid-message: the grant is held indefinitely; starvation is bounded only by the requester.
- MaxBurst release without last: the requester re-arbitrates. The message continues in a later grant.
- Burst count is 8 bits and saturates at MaxBurst. It never wraps.
- tx_thr_empty_i low: the arbiter stalls in GRANT with no write.
- NumReq not a power of two: the rr_ptr wrap is explicit mod NumReq.
- Reset mid-message: the grant is dropped. A partially sent message is not resumed or flagged.

Test Plan:
1. Only req 2 valid, 3 bytes 0x41, 0x42, 0x43(last), thr_empty=1:
   - tx_write_o pulses with 0x41, 0x42, 0x43 two cycles apart; first write 1 cycle after valid.
   - grant_o=4'b0100 throughout, then 0; busy_o low after HOLD.
2. Req 0 and req 1 each send 1-byte messages continuously, NumReq=4:
   - Grants alternate 0,1,0,1.
   - Each requester gets exactly one byte per grant.
   - rr_ptr after first release = 1.
3. Req 3 sends a 20-byte message, last on byte 20; req 0 waiting; MaxBurst=16:
   - Req 3 is released after 16 writes.
   - Req 0 is granted next and sends its byte.
   - Req 3 is re-granted for bytes 17–20.
4. thr_empty held 0 for 10 cycles while the owner is valid:
   - No tx_write_o and ready stays 0.
   - The write occurs the cycle thr_empty returns to 1.
5. Assert rst_ni=0 asynchronously mid-burst, between clock edges:
   - Outputs are 0 immediately, without waiting for a clock edge.
   - After release the arbiter is in IDLE and the scan starts at index 0.
6. Owner req 1 deasserts valid after byte 2, req 2 valid:
   - No grant change. Req 2 ready stays 0.
   - Req 1 resumes and sends its last byte, then req 2 is granted.
